if_fetch_unit: RTL
==================

Name: if_fetch_unit

Overview:
Instruction fetch stage. It owns the PC and issues single-outstanding read requests on the imem port. It buffers returned instruction words in a small FIFO and presents them to the decode stage over a valid/ready handshake. Decode sees each word as {inst, pc, pc_next, order}. A redirect input flushes the buffer and any in-flight fetch, then resumes fetching from a new PC.

Parameters:
RESET_PC, 32'h1eceb000, PC of the first fetch after reset.
QUEUE_DEPTH, 2, fetch buffer entries; must be >= 1. The in-flight request counts toward capacity.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  reset, asynchronous, active-low (rst=0 resets); one clock, no other clock domains.
imem_addr  out  32  fetch address; always 4-byte aligned.
imem_rmask  out  4  4'hF for exactly one cycle to issue a request, else 4'h0.
imem_rdata  in  32  instruction word; valid only when imem_resp=1.
imem_resp  in  1  one-cycle response pulse; arrives at least 1 cycle after the request.
id_valid  out  1  head of the fetch buffer is valid.
id_ready  in  1  decode accepts the head this cycle.
id_inst  out  32  head instruction word.
id_pc  out  32  head PC.
id_pc_next  out  32  head PC + 4.
id_order  out  64  retirement order of the head; increments per accepted word.
redirect_valid  in  1  flush and redirect request.
redirect_pc  in  32  new fetch PC; bits [1:0] are forced to 0.

Behaviour:
- Reset (rst=0, asynchronous):
  - pc=RESET_PC, FSM=ISSUE, buffer empty.
  - id_valid=0, imem_rmask=0, imem_addr=RESET_PC, order=0.
  - id_inst, id_pc and id_pc_next read 0.
- FSM states:
  - ISSUE: no request outstanding.
  - WAIT: one request outstanding.
  - DROP: one request outstanding whose response must be discarded.
- ISSUE:
  - If free = QUEUE_DEPTH - count - (push) + (pop) > 0, drive imem_addr=pc and imem_rmask=4'hF, latch req_pc=pc, and go to WAIT.
  - Otherwise hold imem_rmask=0.
  - A request is issued whenever free > 0. The first request goes out in the first cycle after reset deassertion.
- WAIT, on imem_resp=1:
  - Push {imem_rdata, req_pc, req_pc+4} and set pc <= req_pc + 4.
  - If free after this cycle's push/pop is > 0, issue the next request in the same cycle (address req_pc+4) and stay in WAIT. Otherwise go to ISSUE.
  - Sustained throughput is 1 word per cycle when the memory responds with 1-cycle latency and decode is always ready.
- DROP, on imem_resp=1: discard imem_rdata, go to ISSUE, and issue on the next cycle.
- A request is never issued while in DROP.
- imem_resp in ISSUE (no outstanding request) is ignored. This covers a stale response after reset.
- Decode handshake:
  - id_valid = (count != 0).
  - id_inst, id_pc, id_pc_next and id_order come from registers (no combinational path from imem_*).
  - A pop occurs when id_valid && id_ready; the order counter increments on each pop.
  - The head is held stable while id_valid=1 and id_ready=0.
- Buffer: circular, with head/tail pointers wrapping modulo QUEUE_DEPTH.
  - Simultaneous push and pop on a full buffer is legal; count is unchanged.
  - A push is never issued into a full buffer, which is guaranteed by the capacity reservation.
- Redirect (redirect_valid=1) has priority over everything else in that cycle:
  - The buffer is flushed (count=0, pointers reset) and no pop occurs; order does not increment.
  - Set pc <= {redirect_pc[31:2], 2'b00}.
  - FSM in WAIT or DROP with no imem_resp this cycle: go to DROP.
  - FSM in WAIT or DROP with imem_resp this cycle: the response is discarded; go to ISSUE.
  - FSM in ISSUE: the request that would have issued this cycle is suppressed; go to ISSUE and fetch redirect_pc next cycle.
  - order is not cleared by a redirect.
- Arithmetic: PC increments are 32-bit modulo (0xFFFFFFFC + 4 = 0). order is a 64-bit wrapping counter.

Test Plan:
1. Reset release; memory with 1-cycle latency and word=addr^32'hA5A5A5A5; id_ready=1.
   - Expected: first imem_addr = 0x1eceb000 one cycle after release.
   - Expected: id_pc values 0x1eceb000, 0x1eceb004, 0x1eceb008… on consecutive cycles once flowing.
   - Expected: id_order 0, 1, 2…; no gaps in steady state.
2. id_ready=0 for 10 cycles; memory has 1-cycle latency.
   - Expected: exactly 2 words are buffered and no third request is issued while stalled.
   - Expected: head holds pc 0x1eceb000 unchanged.
   - Expected: after id_ready=1, words drain in order and fetching resumes.
3. Memory with 3-cycle latency; assert redirect_valid with redirect_pc=0x1eceb103 one cycle after a request.
   - Expected: the late response for the old PC is dropped.
   - Expected: next imem_addr = 0x1eceb100.
   - Expected: first id_pc after the redirect = 0x1eceb100; id_valid=0 until then.
4. redirect_valid asserted in the same cycle as imem_resp and id_ready=1 with a full buffer.
   - Expected: no pop and order unchanged; the response is discarded.
   - Expected: the buffer is empty next cycle; the next request goes to the redirect target one cycle later.
5. Assert rst=0 mid-WAIT, then release; the old response arrives after release while in ISSUE.
   - Expected: the response is ignored and fetching restarts at 0x1eceb000.
   - Expected: id_order restarts at 0 and id_valid=0 during reset.
6. redirect_pc=0xFFFFFFFC.
   - Expected: fetched PCs are 0xFFFFFFFC then 0x00000000.
   - Expected: id_pc_next for the first word = 0x00000000.

Source files
------------

// File: rtl/if_fetch_unit_if.sv
// Bundle of the fetch unit's instruction-memory port, decode handshake and redirect request.
// The master side is the fetch unit; the slave side is the memory/decode environment.
`timescale 1ns/1ps
interface if_fetch_unit_if;
  // Instruction memory port
  logic [31:0] imem_addr;
  logic [3:0]  imem_rmask;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  // Decode handshake
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic [31:0] id_pc_next;
  logic [63:0] id_order;
  // Flush / redirect request
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  modport master (
    output imem_addr, imem_rmask, id_valid, id_inst, id_pc, id_pc_next, id_order,
    input  imem_rdata, imem_resp, id_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_addr, imem_rmask, id_valid, id_inst, id_pc, id_pc_next, id_order,
    output imem_rdata, imem_resp, id_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps at most one imem read in flight,
// buffers returned words in a small circular queue and hands them to decode.
//
// Handshake: a word moves to decode on every rising edge where id_valid=1 and
// id_ready=1; while id_valid=1 and id_ready=0 the head fields are held stable.
// id_valid never depends on id_ready. A redirect in the same cycle cancels the
// transfer. On the memory side a request is the single cycle imem_rmask=4'hF,
// and its response is the later single cycle imem_resp=1.
`timescale 1ns/1ps
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h1eceb000,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  if_fetch_unit_if.master bus,
  output logic [1:0]      dbg_state_o
);

  localparam int            PW         = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int            CW         = $clog2(QUEUE_DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR   = PW'(QUEUE_DEPTH - 1);
  localparam logic [CW:0]   DEPTH_C    = (CW + 1)'(QUEUE_DEPTH);
  localparam logic [31:0]   RESET_PC_A = RESET_PC & 32'hFFFF_FFFC;

  // ISSUE: nothing outstanding; WAIT: one request outstanding;
  // DROP: one request outstanding whose response is thrown away.
  typedef enum logic [1:0] {
    ST_ISSUE = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DROP  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   req_pc_q, req_pc_d;
  logic [63:0]   order_q, order_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [31:0]   inst_q    [QUEUE_DEPTH];
  logic [31:0]   pcb_q     [QUEUE_DEPTH];
  logic [31:0]   pcn_q     [QUEUE_DEPTH];

  logic          resp_wait;
  logic          push;
  logic          pop;
  logic          room;
  logic          issue;
  logic [CW:0]   count_after;
  logic [31:0]   seq_pc;
  logic [31:0]   fetch_pc;

  assign seq_pc = req_pc_q + 32'd4;

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_ISSUE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; redirect overrides everything and only keeps DROP if a request is still out
  always_comb begin
    state_d = state_q;
    if (bus.redirect_valid) begin
      state_d = (state_q == ST_ISSUE || bus.imem_resp) ? ST_ISSUE : ST_DROP;
    end else begin
      case (state_q)
        ST_ISSUE: if (issue) state_d = ST_WAIT;
        ST_WAIT:  if (bus.imem_resp) state_d = issue ? ST_WAIT : ST_ISSUE;
        ST_DROP:  if (bus.imem_resp) state_d = ST_ISSUE;
        default:  state_d = ST_ISSUE;
      endcase
    end
  end

  // FSM outputs: push/pop decisions, request issue (capacity includes the in-flight word) and decode view
  always_comb begin
    resp_wait   = (state_q == ST_WAIT) && bus.imem_resp;
    push        = resp_wait && !bus.redirect_valid;
    pop         = (count_q != '0) && bus.id_ready && !bus.redirect_valid;
    count_after = {1'b0, count_q} + {{CW{1'b0}}, push} - {{CW{1'b0}}, pop};
    room        = count_after < DEPTH_C;
    fetch_pc    = resp_wait ? seq_pc : pc_q;
    issue       = 1'b0;
    case (state_q)
      ST_ISSUE: issue = room;
      ST_WAIT:  issue = bus.imem_resp && room;
      default:  issue = 1'b0;
    endcase
    issue = issue && rst && !bus.redirect_valid;

    bus.imem_addr  = fetch_pc;
    bus.imem_rmask = issue ? 4'hF : 4'h0;
    bus.id_valid   = (count_q != '0);
    bus.id_inst    = inst_q[head_q];
    bus.id_pc      = pcb_q[head_q];
    bus.id_pc_next = pcn_q[head_q];
    bus.id_order   = order_q;
    dbg_state_o    = state_q;
  end

  // Datapath next values: PC, request PC, order and queue pointers
  always_comb begin
    pc_d     = pc_q;
    req_pc_d = issue ? fetch_pc : req_pc_q;
    order_d  = pop ? order_q + 64'd1 : order_q;
    count_d  = count_after[CW-1:0];
    head_d   = head_q;
    tail_d   = tail_q;
    if (bus.redirect_valid) begin
      pc_d    = bus.redirect_pc & 32'hFFFF_FFFC;
      count_d = '0;
      head_d  = '0;
      tail_d  = '0;
    end else begin
      if (push) pc_d = seq_pc;
      if (pop)  head_d = (head_q == LAST_PTR) ? '0 : head_q + PW'(1);
      if (push) tail_d = (tail_q == LAST_PTR) ? '0 : tail_q + PW'(1);
    end
  end

  // Datapath registers and fetch buffer storage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q     <= RESET_PC_A;
      req_pc_q <= RESET_PC_A;
      order_q  <= '0;
      count_q  <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        inst_q[i] <= '0;
        pcb_q[i]  <= '0;
        pcn_q[i]  <= '0;
      end
    end else begin
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      order_q  <= order_d;
      count_q  <= count_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      if (push) begin
        inst_q[tail_q] <= bus.imem_rdata;
        pcb_q[tail_q]  <= req_pc_q;
        pcn_q[tail_q]  <= seq_pc;
      end
    end
  end

endmodule
